i2c_arb: RTL and testbench
==========================

I2C_ARB -- requirements
Module: i2c_arb

Interface
REQ-001 Parameter: TO_CYC, default 24'd1000000, WAIT-state timeout in clk cycles (used only with I2C_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  system clock; all state on its rising edge.
REQ-003 rstb  input  1  reset, asynchronous, active-low.
REQ-004 r0_req, r1_req  input  1 each  requester N transaction request, held high until rN_done.
REQ-005 r0_rw, r1_rw  input  1 each  1 = read, 0 = write.
REQ-006 r0_addr, r1_addr  input  7 each  I2C slave address.
REQ-007 r0_wdata, r1_wdata  input  8 each  write byte.
REQ-008 r0_gnt, r1_gnt  output  1 each  requester N owns the I2C master.
REQ-009 r0_done, r1_done  output  1 each  one-cycle completion pulse.
REQ-010 r0_err, r1_err  output  1 each  status of last transaction (NACK/timeout), valid from rN_done.
REQ-011 r0_rdata, r1_rdata  output  8 each  last read byte, held until next read completion for that requester.
REQ-012 m_start  output  1  one-cycle command strobe to byte-level I2C master.
REQ-013 m_rw / m_addr / m_wdata  output  1/7/8  latched command, stable from m_start until DONE.
REQ-014 m_busy  input  1  master busy; m_start not issued while high.
REQ-015 m_done  input  1  one-cycle completion pulse from master.
REQ-016 m_nack  input  1  NACK status, valid with m_done.
REQ-017 m_rdata  input  8  read byte, valid with m_done.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-019 IDLE: at edge with any req high: select winner, latch its rw/addr/wdata into m_*, set rN_gnt, go ISSUE.
REQ-020 Both req high in IDLE: winner is requester not served last (round-robin pointer `last`).
REQ-021 Single req: that requester wins regardless of `last`.
REQ-022 ISSUE: if m_busy low, m_start=1 for exactly one cycle, go WAIT; else remain in ISSUE, m_start low.
REQ-023 WAIT: at edge sampling m_done=1: rN_done<=1, rN_err<=m_nack, rN_rdata<=m_rdata when read and m_nack=0, go DONE.
REQ-024 DONE: rN_done<=0, rN_gnt<=0, last<=winner, go IDLE; minimum one IDLE cycle between transactions.
REQ-025 m_done outside WAIT ignored.
REQ-026 req deasserted mid-transaction ignored; transaction completes and rN_done still pulses.
REQ-027 Loser's req and command inputs not sampled until next IDLE arbitration.
REQ-028 Latency: req sampled at edge k, m_busy low -> m_start high cycle after edge k+1; rN_done high one cycle after m_done sampled.
REQ-029 At most one rN_gnt high at any time.

Reset
REQ-030 rstb low: state IDLE, all outputs 0 (gnt, done, err, rdata, m_start, m_rw, m_addr, m_wdata), last=1 (r0 wins first tie), timeout counter 0.
REQ-031 Reset mid-transaction abandons it; no rN_done pulse after release.

Configuration
REQ-032 Macro I2C_ARB_TIMEOUT_EN defined: 24-bit counter cleared on WAIT entry, increments each WAIT cycle; reaching TO_CYC-1 without m_done -> rN_done=1, rN_err=1, rdata unchanged, output m_abort (1 bit) pulses one cycle, go DONE.
REQ-033 m_done on same edge as timeout: m_done wins, normal completion, no m_abort.
REQ-034 Macro undefined: no counter, no m_abort port, WAIT unbounded.

Verification
REQ-035 r0 write addr 7'h50 data 8'hA5, m_done after 10 cycles m_nack=0 -> single m_start, m_addr=50 m_wdata=A5, r0_done pulse, r0_err=0.
REQ-036 r0 and r1 req same edge after reset -> r0 granted first, r1 second, then third tie goes r0; r0_gnt/r1_gnt never both high.
REQ-037 r1 read, m_busy high 5 cycles at ISSUE -> m_start only after m_busy low; m_rdata=8'h3C, m_nack=0 -> r1_rdata=3C, r1_err=0.
REQ-038 r0 read with m_nack=1, m_rdata=8'hFF -> r0_err=1, r0_rdata retains prior value; spurious m_done in IDLE -> no response.
REQ-039 rstb low during WAIT -> outputs 0, no done pulse; next r1 request serviced normally.
REQ-040 I2C_ARB_TIMEOUT_EN, TO_CYC=16, no m_done -> m_abort and r0_done/r0_err=1 after 16 WAIT cycles; m_done on cycle 16 -> normal completion, no m_abort.

Source files
------------

// File: rtl/i2c_arb.sv
`default_nettype none
// ==========================================================================
// Module   : i2c_arb -- round-robin arbiter sharing one byte-level I2C master
//            between two requesters. Optional WAIT timeout: I2C_ARB_TIMEOUT_EN
// Revision : 1.0
// ==========================================================================
module i2c_arb #(
  parameter logic [23:0] TO_CYC = 24'd1000000
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       r0_req,
  input  logic       r0_rw,
  input  logic [6:0] r0_addr,
  input  logic [7:0] r0_wdata,
  input  logic       r1_req,
  input  logic       r1_rw,
  input  logic [6:0] r1_addr,
  input  logic [7:0] r1_wdata,
  output logic       r0_gnt,
  output logic       r0_done,
  output logic       r0_err,
  output logic [7:0] r0_rdata,
  output logic       r1_gnt,
  output logic       r1_done,
  output logic       r1_err,
  output logic [7:0] r1_rdata,
  output logic       m_start,
  output logic       m_rw,
  output logic [6:0] m_addr,
  output logic [7:0] m_wdata,
`ifdef I2C_ARB_TIMEOUT_EN
  output logic       m_abort,
`endif
  input  logic       m_busy,
  input  logic       m_done,
  input  logic       m_nack,
  input  logic [7:0] m_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        win_q, win_d;
  logic        last_q, last_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  rdata0_q, rdata0_d;
  logic [7:0]  rdata1_q, rdata1_d;
  logic        m_start_q, m_start_d;
  logic        m_rw_q, m_rw_d;
  logic [6:0]  m_addr_q, m_addr_d;
  logic [7:0]  m_wdata_q, m_wdata_d;
`ifdef I2C_ARB_TIMEOUT_EN
  logic [23:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;
`else
  logic        unused_to_cyc;
  assign unused_to_cyc = ^TO_CYC;
`endif

  // A lone requester always wins; on a tie the one not served last wins.
  logic pick;
  assign pick = (r0_req && r1_req) ? ~last_q : r1_req;

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    done_d    = 2'b00;
    err_d     = err_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    m_start_d = 1'b0;
    m_rw_d    = m_rw_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    abort_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          win_d     = pick;
          gnt_d     = pick ? 2'b10 : 2'b01;
          m_rw_d    = pick ? r1_rw    : r0_rw;
          m_addr_d  = pick ? r1_addr  : r0_addr;
          m_wdata_d = pick ? r1_wdata : r0_wdata;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!m_busy) begin
          m_start_d = 1'b1;
          state_d   = S_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_d     = 24'd0;
`endif
        end
      end
      S_WAIT: begin
        // m_done has priority over a timeout expiring on the same edge.
        if (m_done) begin
          done_d[win_q] = 1'b1;
          err_d[win_q]  = m_nack;
          if (m_rw_q && !m_nack) begin
            if (win_q) rdata1_d = m_rdata;
            else       rdata0_d = m_rdata;
          end
          state_d = S_DONE;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (cnt_q == TO_CYC - 24'd1) begin
          done_d[win_q] = 1'b1;
          err_d[win_q]  = 1'b1;
          abort_d       = 1'b1;
          state_d       = S_DONE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
`endif
      end
      S_DONE: begin
        gnt_d   = 2'b00;
        last_d  = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= S_IDLE;
      win_q     <= 1'b0;
      last_q    <= 1'b1;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      err_q     <= 2'b00;
      rdata0_q  <= 8'h00;
      rdata1_q  <= 8'h00;
      m_start_q <= 1'b0;
      m_rw_q    <= 1'b0;
      m_addr_q  <= 7'h00;
      m_wdata_q <= 8'h00;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q     <= 24'd0;
      abort_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      m_start_q <= m_start_d;
      m_rw_q    <= m_rw_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
`endif
    end
  end

  assign r0_gnt   = gnt_q[0];
  assign r1_gnt   = gnt_q[1];
  assign r0_done  = done_q[0];
  assign r1_done  = done_q[1];
  assign r0_err   = err_q[0];
  assign r1_err   = err_q[1];
  assign r0_rdata = rdata0_q;
  assign r1_rdata = rdata1_q;
  assign m_start  = m_start_q;
  assign m_rw     = m_rw_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign m_abort  = abort_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_arb.sv
`default_nettype none
// tb_i2c_arb: arbitration vectors from a table with a completion scoreboard,
// plus hand sequences for spurious m_done, reset during WAIT and the timeout option.
module tb_i2c_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstb;
  logic       r0_req, r0_rw, r1_req, r1_rw;
  logic [6:0] r0_addr, r1_addr;
  logic [7:0] r0_wdata, r1_wdata;
  logic       r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
  logic [7:0] r0_rdata, r1_rdata;
  logic       m_start, m_rw;
  logic [6:0] m_addr;
  logic [7:0] m_wdata;
  logic       m_busy, m_done, m_nack;
  logic [7:0] m_rdata;
`ifdef I2C_ARB_TIMEOUT_EN
  logic       m_abort;
`endif

  i2c_arb #(.TO_CYC(24'd16)) dut (
    .clk(clk), .rstb(rstb),
    .r0_req(r0_req), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
`ifdef I2C_ARB_TIMEOUT_EN
    .m_abort(m_abort),
`endif
    .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
  );

  typedef struct {
    bit         r0, r1, rw0, rw1;
    logic [6:0] a0, a1;
    logic [7:0] w0, w1;
    int         busy, dly;
    bit         nack;
    logic [7:0] rd;
    bit         win, hold;
  } vec_t;

  typedef struct {
    bit         win;
    bit         err;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] rd_model [2];
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;

  function automatic vec_t mk(input bit r0, r1, rw0, rw1,
                              input logic [6:0] a0, a1, input logic [7:0] w0, w1,
                              input int busy, dly, input bit nack,
                              input logic [7:0] rd, input bit win, hold);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.rw0 = rw0; v.rw1 = rw1;
    v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
    v.busy = busy; v.dly = dly; v.nack = nack; v.rd = rd;
    v.win = win; v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_reset();
    chk("rst_ctl", {25'd0, r1_gnt, r0_gnt, r1_done, r0_done, r1_err, r0_err, m_start}, 32'd0);
    chk("rst_rdata", {16'd0, r1_rdata, r0_rdata}, 32'd0);
    chk("rst_cmd", {16'd0, m_rw, m_addr, m_wdata}, 32'd0);
`ifdef I2C_ARB_TIMEOUT_EN
    chk("rst_abort", {31'd0, m_abort}, 32'd0);
`endif
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending transaction.
  always @(negedge clk) begin
    if (rstb && (r0_gnt || r1_gnt))
      chk("gnt_exclusive", {31'd0, r0_gnt & r1_gnt}, 32'd0);
    if (r0_done || r1_done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", {30'd0, r1_done, r0_done}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_who", {30'd0, r1_done, r0_done}, mon_e.win ? 32'd2 : 32'd1);
        chk("err", {31'd0, mon_e.win ? r1_err : r0_err}, {31'd0, mon_e.err});
        chk("rdata", {24'd0, mon_e.win ? r1_rdata : r0_rdata}, {24'd0, mon_e.rdata});
      end
    end
  end

  task automatic start_txn(input vec_t v, input bit to_mode);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    r0_req = v.r0; r0_rw = v.rw0; r0_addr = v.a0; r0_wdata = v.w0;
    r1_req = v.r1; r1_rw = v.rw1; r1_addr = v.a1; r1_wdata = v.w1;
    m_busy = (v.busy > 0);
    e.win   = v.win;
    e.err   = to_mode ? 1'b1 : v.nack;
    e.rdata = ((v.win ? v.rw1 : v.rw0) && !v.nack && !to_mode) ? v.rd : rd_model[v.win];
    rd_model[v.win] = e.rdata;
    sb.push_back(e);
    n = 0;
    while (m_start !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (n == v.busy + 1) m_busy = 1'b0;
    end
    chk("start_lat", n, 2 + v.busy);
    chk("gnt", {30'd0, r1_gnt, r0_gnt}, v.win ? 32'd2 : 32'd1);
    chk("cmd", {16'd0, m_rw, m_addr, m_wdata},
        v.win ? {16'd0, v.rw1, v.a1, v.w1} : {16'd0, v.rw0, v.a0, v.w0});
    if (!v.hold) begin
      r0_req = 1'b0; r1_req = 1'b0;
    end else if (v.win) r0_req = 1'b0;
    else r1_req = 1'b0;
    @(posedge clk); #1;
    chk("start_pulse", {31'd0, m_start}, 32'd0);
  endtask

  task automatic finish_txn(input vec_t v);
    int n;
    repeat (v.dly) begin @(posedge clk); #1; end
    m_done = 1'b1; m_nack = v.nack; m_rdata = v.rd;
    @(posedge clk); #1;
    m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
    n = 0;
    while (!(r0_done || r1_done) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_latency", n, 0);
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("gnt_release", {30'd0, r1_gnt, r0_gnt}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    start_txn(v, 1'b0);
    finish_txn(v);
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic to_txn(input vec_t v, input bit late_done);
    start_txn(v, !late_done);
    repeat (14) begin @(posedge clk); #1; end
    chk("abort_early", {30'd0, m_abort, r0_done | r1_done}, 32'd0);
    if (late_done) begin m_done = 1'b1; m_nack = v.nack; m_rdata = v.rd; end
    @(posedge clk); #1;
    m_done = 1'b0; m_nack = 1'b0;
    chk("abort", {31'd0, m_abort}, {31'd0, !late_done});
    chk("to_done", {31'd0, v.win ? r1_done : r0_done}, 32'd1);
    @(posedge clk); #1;
    chk("abort_pulse", {31'd0, m_abort}, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    chk("to_gnt_release", {30'd0, r1_gnt, r0_gnt}, 32'd0);
  endtask
`endif

  task automatic spurious_done();
    int d0;
    @(posedge clk); #1;
    d0 = done_cnt;
    m_done = 1'b1; m_nack = 1'b1; m_rdata = 8'hEE;
    @(posedge clk); #1;
    m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
    repeat (3) begin @(posedge clk); #1; end
    chk("spurious_done", done_cnt, d0);
    chk("spurious_gnt", {30'd0, r1_gnt, r0_gnt}, 32'd0);
    chk("spurious_rdata", {16'd0, r1_rdata, r0_rdata}, {16'd0, rd_model[1], rd_model[0]});
  endtask

  vec_t tbl [8];

  initial begin
    rstb = 1'b0;
    r0_req = 0; r0_rw = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_rw = 0; r1_addr = 0; r1_wdata = 0;
    m_busy = 0; m_done = 0; m_nack = 0; m_rdata = 0;
    rd_model[0] = 8'h00; rd_model[1] = 8'h00;

    //          r0 r1 rw0 rw1 a0     a1     w0     w1     busy dly nack rd     win hold
    tbl[0] = mk(1, 1, 0,  0,  7'h11, 7'h12, 8'h22, 8'h33, 0,   2,  0,   8'h00, 0,  1);
    tbl[1] = mk(1, 1, 0,  1,  7'h21, 7'h22, 8'h44, 8'h55, 0,   3,  0,   8'h66, 1,  1);
    tbl[2] = mk(1, 1, 1,  0,  7'h31, 7'h32, 8'h77, 8'h88, 0,   0,  0,   8'h99, 0,  0);
    tbl[3] = mk(1, 0, 0,  0,  7'h50, 7'h00, 8'hA5, 8'h00, 0,   10, 0,   8'h00, 0,  1);
    tbl[4] = mk(0, 1, 0,  1,  7'h00, 7'h2A, 8'h00, 8'h00, 5,   4,  0,   8'h3C, 1,  1);
    tbl[5] = mk(1, 0, 1,  0,  7'h48, 7'h00, 8'h00, 8'h00, 0,   1,  1,   8'hFF, 0,  1);
    tbl[6] = mk(0, 1, 0,  0,  7'h00, 7'h3F, 8'h00, 8'hC7, 2,   6,  1,   8'h00, 1,  0);
    tbl[7] = mk(0, 1, 0,  1,  7'h00, 7'h13, 8'h00, 8'h00, 0,   1,  0,   8'h5E, 1,  1);

    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rstb = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    spurious_done();

    // Reset while the master is still working on r0's command.
    start_txn(mk(1, 0, 0, 0, 7'h70, 7'h00, 8'h0F, 8'h00, 0, 0, 0, 8'h00, 0, 0), 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rstb = 1'b0;
    #2;
    chk_reset();
    sb.delete();
    rd_model[0] = 8'h00; rd_model[1] = 8'h00;
    @(posedge clk); #1;
    rstb = 1'b1;
    spurious_done();
    run_vec(mk(0, 1, 0, 1, 7'h00, 7'h1D, 8'h00, 8'h00, 1, 3, 0, 8'hC3, 1, 1));

`ifdef I2C_ARB_TIMEOUT_EN
    to_txn(mk(1, 0, 1, 0, 7'h41, 7'h00, 8'h00, 8'h00, 0, 0, 0, 8'hAB, 0, 0), 1'b0);
    to_txn(mk(1, 0, 1, 0, 7'h42, 7'h00, 8'h00, 8'h00, 0, 0, 0, 8'hAB, 0, 0), 1'b1);
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
